// File: rtl/pcie_eq_pkg.sv
// Shared definitions for the PCIe transmitter equalisation coefficient responder.
// Contents:
//   eq_state_e      - responder FSM states
//   NUM_PRESETS     - number of defined presets (P0..P10)
//   PRESET_*_DEF    - default precursor/postcursor tables for FS=24, P0 in the LSBs
//   preset_field()  - extracts one 6-bit entry from a packed preset table
package pcie_eq_pkg;

    localparam int NUM_PRESETS = 11;
    localparam int COEF_W      = 6;
    localparam int TAB_W       = NUM_PRESETS * COEF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        CHECK  = 2'd2,
        RESP   = 2'd3
    } eq_state_e;

    // C-1 per preset, ordered {P10 .. P0}
    localparam logic [TAB_W-1:0] PRESET_PRE_DEF = {
        6'd0, 6'd4, 6'd3, 6'd2, 6'd3, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0
    };

    // C+1 per preset, ordered {P10 .. P0}
    localparam logic [TAB_W-1:0] PRESET_POST_DEF = {
        6'd8, 6'd0, 6'd4, 6'd5, 6'd0, 6'd0, 6'd0, 6'd3, 6'd5, 6'd4, 6'd6
    };

    function automatic logic [COEF_W-1:0] preset_field(input logic [TAB_W-1:0] tab,
                                                       input logic [3:0]       idx);
        logic [TAB_W-1:0] sh;
        sh = tab >> (int'(idx) * COEF_W);
        return sh[COEF_W-1:0];
    endfunction

endpackage

// File: rtl/pcie_eq_coef_check.sv
// Combinational legality evaluation of a coefficient set.
// Ports:
//   pre_i, post_i  - candidate C-1 / C+1 (unsigned coefficient units)
//   fs_i, lf_i     - full-swing value and low-frequency limit
//   reserved_i     - request referred to an undefined preset
//   main_o         - C0 = FS - pre - post, 7-bit signed (clamped, sign always correct)
//   legal_o        - set set when the coefficient set may be applied
module pcie_eq_coef_check (
    input  logic        [5:0] pre_i,
    input  logic        [5:0] post_i,
    input  logic        [5:0] fs_i,
    input  logic        [5:0] lf_i,
    input  logic              reserved_i,
    output logic signed [6:0] main_o,
    output logic              legal_o
);

    // Worst-case operands (pre=post=63) would wrap a 7/8-bit result and flip
    // its sign, so the sums are formed at 9 bits and only narrowed afterwards.
    logic signed [8:0] main_w;
    logic signed [8:0] margin_w;

    function automatic logic signed [6:0] sat_main(input logic signed [8:0] w);
        if (w > 9'sd63) begin
            return 7'sd63;
        end else if (w < -9'sd64) begin
            return -7'sd64;
        end
        return w[6:0];
    endfunction

    always_comb begin
        main_w   = $signed({3'b000, fs_i}) - $signed({3'b000, pre_i}) - $signed({3'b000, post_i});
        margin_w = main_w - $signed({3'b000, pre_i}) - $signed({3'b000, post_i});
        legal_o  = !reserved_i
                && !main_w[8]
                && (pre_i <= (fs_i >> 2))
                && (margin_w >= $signed({3'b000, lf_i}));
        main_o   = sat_main(main_w);
    end

endmodule

// File: rtl/pcie_eq_coef_responder.sv
// Responds to link-partner equalisation requests (preset or explicit C-1/C+1),
// evaluates legality, returns the evaluated coefficients and applies accepted
// sets to the transmitter driver.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   req_valid/req_ready           - request handshake (ready only in IDLE)
//   req_is_preset, req_preset     - preset request and preset number
//   req_pre, req_post             - explicit C-1 / C+1 request
//   rsp_valid/rsp_ready           - response handshake
//   rsp_accept, rsp_pre/main/post - verdict and evaluated coefficients
//   tx_pre/main/post              - coefficients currently driving the transmitter
//   reject_cnt                    - saturating count of rejected requests
module pcie_eq_coef_responder
    import pcie_eq_pkg::*;
#(
    parameter logic [5:0]       FS              = 6'd24,
    parameter logic [5:0]       LF              = 6'd8,
    parameter logic [TAB_W-1:0] PRESET_PRE_TAB  = PRESET_PRE_DEF,
    parameter logic [TAB_W-1:0] PRESET_POST_TAB = PRESET_POST_DEF,
    parameter logic [3:0]       RESET_PRESET    = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_preset,
    input  logic [3:0] req_preset,
    input  logic [5:0] req_pre,
    input  logic [5:0] req_post,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_accept,
    output logic [5:0] rsp_pre,
    output logic [5:0] rsp_main,
    output logic [5:0] rsp_post,
    output logic [5:0] tx_pre,
    output logic [5:0] tx_main,
    output logic [5:0] tx_post,
    output logic [7:0] reject_cnt
);

    localparam logic [5:0] RST_PRE    = preset_field(PRESET_PRE_TAB, RESET_PRESET);
    localparam logic [5:0] RST_POST   = preset_field(PRESET_POST_TAB, RESET_PRESET);
    localparam logic [5:0] RST_MAIN   = FS - RST_PRE - RST_POST;
    localparam logic [3:0] MAX_PRESET = 4'(NUM_PRESETS - 1);

    eq_state_e state_q, state_d;

    logic       is_preset_q, is_preset_d;
    logic [3:0] preset_q, preset_d;
    logic [5:0] req_pre_q, req_pre_d;
    logic [5:0] req_post_q, req_post_d;
    logic [5:0] pre_q, pre_d;
    logic [5:0] post_q, post_d;
    logic       reserved_q, reserved_d;
    logic       accept_q, accept_d;
    logic [5:0] rsp_pre_q, rsp_pre_d;
    logic [5:0] rsp_main_q, rsp_main_d;
    logic [5:0] rsp_post_q, rsp_post_d;
    logic [5:0] tx_pre_q, tx_pre_d;
    logic [5:0] tx_main_q, tx_main_d;
    logic [5:0] tx_post_q, tx_post_d;
    logic [7:0] rej_q, rej_d;

    logic signed [6:0] chk_main;
    logic              chk_legal;

    pcie_eq_coef_check u_check (
        .pre_i      (pre_q),
        .post_i     (post_q),
        .fs_i       (FS),
        .lf_i       (LF),
        .reserved_i (reserved_q),
        .main_o     (chk_main),
        .legal_o    (chk_legal)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = LOOKUP;
            LOOKUP:  state_d = CHECK;
            CHECK:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state logic, each register advancing in its own FSM phase
    always_comb begin
        is_preset_d = is_preset_q;
        preset_d    = preset_q;
        req_pre_d   = req_pre_q;
        req_post_d  = req_post_q;
        pre_d       = pre_q;
        post_d      = post_q;
        reserved_d  = reserved_q;
        accept_d    = accept_q;
        rsp_pre_d   = rsp_pre_q;
        rsp_main_d  = rsp_main_q;
        rsp_post_d  = rsp_post_q;
        tx_pre_d    = tx_pre_q;
        tx_main_d   = tx_main_q;
        tx_post_d   = tx_post_q;
        rej_d       = rej_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_preset_d = req_is_preset;
                    preset_d    = req_preset;
                    req_pre_d   = req_pre;
                    req_post_d  = req_post;
                end
            end
            LOOKUP: begin
                reserved_d = 1'b0;
                pre_d      = req_pre_q;
                post_d     = req_post_q;
                if (is_preset_q) begin
                    if (preset_q <= MAX_PRESET) begin
                        pre_d  = preset_field(PRESET_PRE_TAB, preset_q);
                        post_d = preset_field(PRESET_POST_TAB, preset_q);
                    end else begin
                        // Undefined preset: coefficients are reported as zero
                        reserved_d = 1'b1;
                        pre_d      = 6'd0;
                        post_d     = 6'd0;
                    end
                end
            end
            CHECK: begin
                accept_d   = chk_legal;
                rsp_pre_d  = pre_q;
                rsp_post_d = post_q;
                rsp_main_d = chk_main[6] ? 6'd0 : chk_main[5:0];
            end
            RESP: begin
                if (rsp_ready) begin
                    if (accept_q) begin
                        tx_pre_d  = rsp_pre_q;
                        tx_main_d = rsp_main_q;
                        tx_post_d = rsp_post_q;
                    end else if (rej_q != 8'hFF) begin
                        rej_d = rej_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_preset_q <= 1'b0;
            preset_q    <= 4'd0;
            req_pre_q   <= 6'd0;
            req_post_q  <= 6'd0;
            pre_q       <= 6'd0;
            post_q      <= 6'd0;
            reserved_q  <= 1'b0;
            accept_q    <= 1'b0;
            rsp_pre_q   <= 6'd0;
            rsp_main_q  <= 6'd0;
            rsp_post_q  <= 6'd0;
            tx_pre_q    <= RST_PRE;
            tx_main_q   <= RST_MAIN;
            tx_post_q   <= RST_POST;
            rej_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            is_preset_q <= is_preset_d;
            preset_q    <= preset_d;
            req_pre_q   <= req_pre_d;
            req_post_q  <= req_post_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            reserved_q  <= reserved_d;
            accept_q    <= accept_d;
            rsp_pre_q   <= rsp_pre_d;
            rsp_main_q  <= rsp_main_d;
            rsp_post_q  <= rsp_post_d;
            tx_pre_q    <= tx_pre_d;
            tx_main_q   <= tx_main_d;
            tx_post_q   <= tx_post_d;
            rej_q       <= rej_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_accept = accept_q;
    assign rsp_pre    = rsp_pre_q;
    assign rsp_main   = rsp_main_q;
    assign rsp_post   = rsp_post_q;
    assign tx_pre     = tx_pre_q;
    assign tx_main    = tx_main_q;
    assign tx_post    = tx_post_q;
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_pcie_eq_coef_responder.sv
// Self-checking bench for pcie_eq_coef_responder (FS=24, LF=8, default tables).
module tb_pcie_eq_coef_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_is_preset;
    logic [3:0] req_preset;
    logic [5:0] req_pre;
    logic [5:0] req_post;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_accept;
    logic [5:0] rsp_pre, rsp_main, rsp_post;
    logic [5:0] tx_pre, tx_main, tx_post;
    logic [7:0] reject_cnt;

    // standalone rule evaluator, exercised against hand-computed constants
    logic [5:0]        r_pre, r_post;
    logic signed [6:0] r_main;
    logic              r_legal;

    always #5 clk = ~clk;

    pcie_eq_coef_responder #(
        .FS (6'd24),
        .LF (6'd8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_preset (req_is_preset),
        .req_preset    (req_preset),
        .req_pre       (req_pre),
        .req_post      (req_post),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_accept    (rsp_accept),
        .rsp_pre       (rsp_pre),
        .rsp_main      (rsp_main),
        .rsp_post      (rsp_post),
        .tx_pre        (tx_pre),
        .tx_main       (tx_main),
        .tx_post       (tx_post),
        .reject_cnt    (reject_cnt)
    );

    pcie_eq_coef_check ref_chk (
        .pre_i      (r_pre),
        .post_i     (r_post),
        .fs_i       (6'd24),
        .lf_i       (6'd8),
        .reserved_i (1'b0),
        .main_o     (r_main),
        .legal_o    (r_legal)
    );

    typedef struct {
        bit         is_preset;
        logic [3:0] preset;
        logic [5:0] pre;
        logic [5:0] post;
        bit         acc;
        logic [5:0] epre;
        logic [5:0] emain;
        logic [5:0] epost;
        bit         cc;       // compare returned coefficients
    } vec_t;

    vec_t vecs[13];
    vec_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] m_tx_pre, m_tx_main, m_tx_post;
    int         m_cnt;

    function automatic vec_t mk(bit ip, int pn, int pr, int po, bit a, int ep, int em, int eo, bit c);
        vec_t v;
        v.is_preset = ip;
        v.preset    = 4'(pn);
        v.pre       = 6'(pr);
        v.post      = 6'(po);
        v.acc       = a;
        v.epre      = 6'(ep);
        v.emain     = 6'(em);
        v.epost     = 6'(eo);
        v.cc        = c;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tx_pre  = 6'd0;
        m_tx_main = 6'd24;
        m_tx_post = 6'd0;
        m_cnt     = 0;
        exp_q.delete();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_tx_pre"}, tx_pre, m_tx_pre);
        chk({tag, "_tx_main"}, tx_main, m_tx_main);
        chk({tag, "_tx_post"}, tx_post, m_tx_post);
        chk({tag, "_reject_cnt"}, reject_cnt, m_cnt);
    endtask

    // One full request/response transaction; hold = cycles rsp_ready stays low
    // once the response is seen, poke = present a stray request during the hold.
    task automatic send(input vec_t r, input int hold, input bit poke);
        int   cyc;
        vec_t e;
        logic [18:0] snap;
        @(negedge clk);
        req_valid     = 1'b1;
        req_is_preset = r.is_preset;
        req_preset    = r.preset;
        req_pre       = r.pre;
        req_post      = r.post;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_before_handshake", req_ready, 1);
        @(posedge clk);
        exp_q.push_back(r);
        #1 req_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_latency", cyc, 3);
        e = exp_q.pop_front();
        chk("rsp_accept", rsp_accept, e.acc);
        if (e.cc) begin
            chk("rsp_pre", rsp_pre, e.epre);
            chk("rsp_main", rsp_main, e.emain);
            chk("rsp_post", rsp_post, e.epost);
        end
        snap = {rsp_accept, rsp_pre, rsp_main, rsp_post};
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 0) begin
                req_valid     = 1'b1;
                req_is_preset = 1'b1;
                req_preset    = 4'd11;
            end
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_stable", {rsp_accept, rsp_pre, rsp_main, rsp_post}, snap);
            chk("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (e.acc) begin
            m_tx_pre  = e.epre;
            m_tx_main = e.emain;
            m_tx_post = e.epost;
        end else if (m_cnt < 255) begin
            m_cnt++;
        end
        chk("back_to_idle", req_ready, 1);
        chk("rsp_valid_dropped", rsp_valid, 0);
        chk_state("post_rsp");
    endtask

    initial begin
        vec_t v7;
        //            ip pn pre post  acc epre emain epost cc
        vecs[0]  = mk(1, 4,  0,  0,   1,  0,  24,  0,  1);  // reset preset
        vecs[1]  = mk(1, 7,  0,  0,   1,  2,  17,  5,  1);
        vecs[2]  = mk(0, 0,  7,  0,   0,  7,  17,  0,  1);  // pre > FS/4
        vecs[3]  = mk(0, 0,  3, 10,   0,  3,  11, 10,  1);  // margin 11-13 < LF
        vecs[4]  = mk(1, 11, 0,  0,   0,  0,   0,  0,  0);  // reserved preset
        vecs[5]  = mk(1, 10, 0,  0,   1,  0,  16,  8,  1);  // margin exactly LF
        vecs[6]  = mk(1, 0,  0,  0,   1,  0,  18,  6,  1);
        vecs[7]  = mk(1, 9,  0,  0,   1,  4,  20,  0,  1);
        vecs[8]  = mk(0, 0,  6,  0,   1,  6,  18,  0,  1);  // pre exactly FS/4
        vecs[9]  = mk(0, 0,  0, 30,   0,  0,   0, 30,  1);  // main < 0 -> 0
        vecs[10] = mk(1, 15, 0,  0,   0,  0,   0,  0,  0);  // reserved preset
        vecs[11] = mk(0, 0,  2,  6,   1,  2,  16,  6,  1);  // margin exactly LF
        vecs[12] = mk(0, 0,  2,  7,   0,  2,  15,  7,  1);  // margin LF-2

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_is_preset = 1'b0; req_preset = 4'd0; req_pre = 6'd0; req_post = 6'd0;
        r_pre = 6'd0; r_post = 6'd0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_accept", rsp_accept, 0);
        chk("reset_rsp_main", rsp_main, 0);
        chk_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);

        // rule evaluator on explicit-coefficient vectors
        foreach (vecs[i]) begin
            if (!vecs[i].is_preset) begin
                r_pre  = vecs[i].pre;
                r_post = vecs[i].post;
                #1;
                chk("ref_legal", r_legal, vecs[i].acc);
                if (vecs[i].emain != 6'd0) chk("ref_main", r_main, vecs[i].emain);
            end
        end
        r_pre = 6'd0; r_post = 6'd30;
        #1 chk("ref_main_negative", r_main, -6);

        // table, back-to-back
        foreach (vecs[i]) send(vecs[i], 0, 1'b0);

        // response stall with stray request while busy
        send(vecs[1], 5, 1'b1);
        send(vecs[3], 2, 1'b1);

        // saturation of the reject counter
        for (int i = 0; i < 300; i++) send(vecs[2], 0, 1'b0);
        chk("reject_cnt_saturated", reject_cnt, 255);

        // reset while a preset 7 request sits in CHECK
        v7 = vecs[1];
        @(negedge clk);
        req_valid = 1'b1; req_is_preset = 1'b1; req_preset = 4'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);          // LOOKUP
        @(negedge clk);          // CHECK
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("midreset_rsp_valid", rsp_valid, 0);
        chk_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_rsp_valid_after", rsp_valid, 0);
        chk_state("after_midreset");
        send(v7, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
